tl_ul_monitor: RTL and testbench
================================

# tl_ul_monitor

Parametrised TileLink-UL protocol monitor for the testbench. It snoops one A/D channel pair without driving it, and tracks outstanding requests per source ID. It checks handshake stability, opcode/size/alignment legality and response matching, and reports violations as registered error codes with a saturating count. It generalises the fixed-width monitor wrappers to arbitrary address/data/source widths, multi-beat bursts and response tracking.

## Interface
- SOURCE_W, 2: source ID width; the table has 2^SOURCE_W entries
- ADDR_W, 30: address width
- DATA_W, 32: data bus width in bits; power of two, ≥8
- SIZE_W, 3: log2(bytes) size field width
- TIMEOUT, 1024: cycles allowed from request first beat to response last beat
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- a_valid, a_ready  in  1  A handshake
- a_opcode  in  3  A opcode
- a_param  in  3  must be 0
- a_size  in  SIZE_W  log2 transfer bytes
- a_source  in  SOURCE_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask  in  DATA_W/8  byte lanes
- d_valid, d_ready  in  1  D handshake
- d_opcode  in  3  D opcode
- d_size  in  SIZE_W  echoed size
- d_source  in  SOURCE_W  response ID
- d_denied, d_corrupt  in  1  status bits; only sampled for stability
- err_valid  out  1  one-cycle pulse: ≥1 violation in the previous cycle
- err_vec  out  9  violation bitmask, bit i = code i+1
- err_code  out  4  lowest set code in err_vec; 0 when none
- err_count  out  16  cycles with ≥1 violation; saturates at 0xFFFF
- inflight  out  SOURCE_W+1  number of valid table entries

## Operation
- Fire: a_fire = a_valid&a_ready; d_fire = d_valid&d_ready.
- Beats: BEAT_LG = log2(DATA_W/8). Beats = 2^(size−BEAT_LG) if size > BEAT_LG, else 1. Only Put carries A data beats, so Get is always 1 A beat. Only AccessAckData carries D data beats.
- Table entry per source: {valid, is_get, size, timer}. Set on the first A beat fire and cleared on the last D beat fire.
- Codes:
  - 1: illegal a_opcode (not 0 PutFull, 1 PutPartial, 4 Get) or a_param≠0.
  - 2: a_address not aligned to 2^a_size.
  - 3: PutFull mask not all lanes covered by size/offset.
  - 4: A stability. A was valid&!ready last cycle, and this cycle a_valid dropped or any A field changed. a_mask is exempt between beats.
  - 5: D stability, with the same rule on D fields.
  - 6: A first beat on a source whose entry is valid.
  - 7: D first beat on a source whose entry is invalid.
  - 8: D opcode/size mismatch. Get must get 1 AccessAckData; Put must get 0 AccessAck; d_size must equal the stored size.
  - 9: timeout.
- Mid-burst beats must repeat source/size/opcode/param; a change raises code 4.
- Simultaneous D last beat and A first beat on the same source: the clear is applied first, so the pair is legal.
- D first beat on a source whose A first beat fires in the same cycle: code 7. Zero-latency responses are illegal.
- After an error the table is still updated. Code 6 overwrites the entry. Code 7 leaves the table unchanged.

## Timing
- All outputs are registered. Violations in cycle N appear on err_* in cycle N+1. err_count and inflight update in N+1.
- Reset values: err_valid=0, err_vec=0, err_code=0, err_count=0, inflight=0. Table, beat counters and stability history are cleared.
- While reset=1, no checks run. In the first cycle after reset, stability checks are suppressed because there is no history.
- Reset mid-burst discards all state; no error is raised for the abandoned transfer.
- Timer: starts at 0 on set and increments each cycle while valid. Code 9 fires in the cycle the timer reaches TIMEOUT, once per entry. The timer then holds.

## Configuration
- TL_MON_TIMEOUT_EN defined: per-entry timers exist and code 9 is active.
- Undefined: timers and TIMEOUT logic are removed, err_vec[8] is tied 0, and TIMEOUT is ignored.

## Structure
- Package tl_mon_pkg holds:
  - opcode constants (PUT_FULL, PUT_PARTIAL, GET, ACK, ACK_DATA)
  - error-code enum (ERR_NONE..ERR_TIMEOUT)
  - a beats-from-size function
- Sub-module tl_mon_beat_ctr is instantiated for A and D. It takes fire/size/has_data and emits first/last.

## Test plan
- Get src 1, addr 0x40, size 2; AccessAckData 2 cycles later → no error, inflight 0→1→0.
- Get addr 0x42, size 2 → err_code 2 next cycle, err_count=1.
- a_valid held with a_ready=0, a_address changes 0x40→0x44 → code 4.
- AccessAck on src 3 with no request → code 7; on matching Get → code 8.
- PutFull size 4 on DATA_W=32 (4 beats), then ack → no error; a second Put on the same source before the ack → code 6.
- With TL_MON_TIMEOUT_EN and TIMEOUT=16: Get with no response → code 9 exactly 16 cycles after the fire, once only.

Source files
------------

// File: rtl/tl_mon_pkg.sv
// TileLink-UL monitor shared definitions: opcodes, error codes, beat helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package tl_mon_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  localparam int N_ERR = 9;

  // Error code i lives in err_vec bit i-1
  typedef enum logic [3:0] {
    ERR_NONE       = 4'd0,
    ERR_A_OPCODE   = 4'd1,
    ERR_A_ALIGN    = 4'd2,
    ERR_A_MASK     = 4'd3,
    ERR_A_STABLE   = 4'd4,
    ERR_D_STABLE   = 4'd5,
    ERR_A_BUSY     = 4'd6,
    ERR_D_ORPHAN   = 4'd7,
    ERR_D_MISMATCH = 4'd8,
    ERR_TIMEOUT    = 4'd9
  } err_code_e;

  // Number of data beats for a transfer of 2^size bytes on a 2^beat_lg byte bus
  function automatic int unsigned beats_from_size(input int unsigned size,
                                                  input int unsigned beat_lg);
    if (size > beat_lg) return 32'd1 << (size - beat_lg);
    return 32'd1;
  endfunction

  // Lowest numbered code present in a violation vector, ERR_NONE if empty
  function automatic logic [3:0] lowest_code(input logic [N_ERR-1:0] vec);
    logic [3:0] code;
    code = ERR_NONE;
    for (int i = N_ERR - 1; i >= 0; i--) begin
      if (vec[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/tl_mon_beat_ctr.sv
// Beat counter for one TileLink channel: flags first/last beat of a burst.
// Latency: first/last are combinational from the count and current size.
// Backpressure: advances only on fire; never stalls the channel.
module tl_mon_beat_ctr #(
  parameter int SIZE_W  = 3,
  parameter int BEAT_LG = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fire,
  input  logic [SIZE_W-1:0] size,
  input  logic              has_data,
  output logic              first,
  output logic              last
);
  import tl_mon_pkg::*;

  // Wide enough for the largest burst of 2^(2^SIZE_W - 1) bytes
  localparam int CNT_W = 2 ** SIZE_W;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_beats;

  // Burst length: data-carrying messages span the size, others are one beat
  always_comb begin
    w_beats = CNT_W'(1);
    if (has_data) w_beats = CNT_W'(beats_from_size(32'(size), 32'(BEAT_LG)));
  end

  assign first = (r_cnt == '0);
  assign last  = (r_cnt == (w_beats - CNT_W'(1)));

  // Count fired beats, wrapping to zero after the last one
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (fire) begin
      r_cnt <= last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tl_ul_monitor.sv
// Passive TileLink-UL A/D monitor: legality, stability, per-source tracking; timers when TL_MON_TIMEOUT_EN.
// Latency: violations in cycle N appear on err_*, err_count and inflight in cycle N+1.
// Backpressure: none; observes a_ready/d_ready only and never drives the link.
module tl_ul_monitor #(
  parameter int SOURCE_W = 2,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic                d_denied,
  input  logic                d_corrupt,
  output logic                err_valid,
  output logic [8:0]          err_vec,
  output logic [3:0]          err_code,
  output logic [15:0]         err_count,
  output logic [SOURCE_W:0]   inflight
);
  import tl_mon_pkg::*;

  localparam int NSRC    = 2 ** SOURCE_W;
  localparam int LANES   = DATA_W / 8;
  localparam int BEAT_LG = $clog2(LANES);
  localparam int INF_W   = SOURCE_W + 1;

  logic w_a_fire, w_d_fire;
  logic w_a_first, w_a_last, w_d_first, w_d_last;
  logic [SIZE_W-1:0] w_a_size_eff;
  logic [2:0]        w_a_op_eff;
  logic w_a_has_data, w_d_has_data;

  // Header of the A burst in progress, used for the later beats
  logic [2:0]          r_ab_opcode, r_ab_param;
  logic [SIZE_W-1:0]   r_ab_size;
  logic [SOURCE_W-1:0] r_ab_source;
  // Whether the D burst in progress was matched to a live entry
  logic                r_d_match;

  // Stall history for the stability checks
  logic                r_a_pend, r_d_pend;
  logic [2:0]          r_ah_opcode, r_ah_param, r_dh_opcode;
  logic [SIZE_W-1:0]   r_ah_size, r_dh_size;
  logic [SOURCE_W-1:0] r_ah_source, r_dh_source;
  logic [ADDR_W-1:0]   r_ah_address;
  logic [LANES-1:0]    r_ah_mask;
  logic                r_dh_denied, r_dh_corrupt;

  // Per-source request table
  logic [NSRC-1:0]   r_vld, r_is_get;
  logic [SIZE_W-1:0] r_size [NSRC];
  logic [NSRC-1:0]   w_vld_n, w_is_get_n;
  logic [SIZE_W-1:0] w_size_n [NSRC];
  logic [INF_W-1:0]  w_infl_n;

  logic w_a_set, w_d_ok, w_d_clr, w_a_busy;
  logic w_misalign;
  logic [LANES-1:0] w_full_mask;
  logic w_timeout;
  logic [N_ERR-1:0] w_vec;

  // Output registers
  logic              r_err_valid;
  logic [8:0]        r_err_vec;
  logic [3:0]        r_err_code;
  logic [15:0]       r_err_count;
  logic [INF_W-1:0]  r_inflight;

  assign w_a_fire = a_valid & a_ready;
  assign w_d_fire = d_valid & d_ready;

  // Later beats are sized by the burst header so a corrupted size cannot derail the count
  assign w_a_size_eff = w_a_first ? a_size : r_ab_size;
  assign w_a_op_eff   = w_a_first ? a_opcode : r_ab_opcode;
  assign w_a_has_data = (w_a_op_eff == PUT_FULL) || (w_a_op_eff == PUT_PARTIAL);
  assign w_d_has_data = (d_opcode == ACK_DATA);

  tl_mon_beat_ctr #(.SIZE_W(SIZE_W), .BEAT_LG(BEAT_LG)) u_a_ctr (
    .clock    (clock),
    .reset    (reset),
    .fire     (w_a_fire),
    .size     (w_a_size_eff),
    .has_data (w_a_has_data),
    .first    (w_a_first),
    .last     (w_a_last)
  );

  tl_mon_beat_ctr #(.SIZE_W(SIZE_W), .BEAT_LG(BEAT_LG)) u_d_ctr (
    .clock    (clock),
    .reset    (reset),
    .fire     (w_d_fire),
    .size     (d_size),
    .has_data (w_d_has_data),
    .first    (w_d_first),
    .last     (w_d_last)
  );

  // Table next state: a D clear lands before an A set so back-to-back reuse is legal
  always_comb begin
    w_vld_n    = r_vld;
    w_is_get_n = r_is_get;
    w_size_n   = r_size;
    w_d_ok     = w_d_first ? r_vld[d_source] : r_d_match;
    w_d_clr    = w_d_fire && w_d_last && w_d_ok;
    w_a_set    = w_a_fire && w_a_first;
    w_a_busy   = r_vld[a_source] && !(w_d_clr && (d_source == a_source));
    if (w_d_clr) w_vld_n[d_source] = 1'b0;
    if (w_a_set) begin
      w_vld_n[a_source]    = 1'b1;
      w_is_get_n[a_source] = (a_opcode == GET);
      w_size_n[a_source]   = a_size;
    end
    w_infl_n = '0;
    for (int i = 0; i < NSRC; i++) w_infl_n = w_infl_n + INF_W'(w_vld_n[i]);
  end

  // Address alignment and the lanes a PutFull of this size/offset must cover
  always_comb begin
    int off;
    w_misalign = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if ((i < int'(a_size)) && a_address[i]) w_misalign = 1'b1;
    end
    off = 0;
    for (int b = 0; b < BEAT_LG; b++) begin
      if (a_address[b]) off = off | (1 << b);
    end
    w_full_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((int'(a_size) >= BEAT_LG) || ((i >= off) && (i < off + (1 << int'(a_size)))))
        w_full_mask[i] = 1'b1;
    end
  end

`ifdef TL_MON_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] r_tmr [NSRC];
  logic [NSRC-1:0]  w_to_hit;

  // An entry times out on the cycle its timer steps onto TIMEOUT, unless it retires then
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_to_hit[i] = r_vld[i] && (r_tmr[i] == TMR_W'(TIMEOUT - 1)) &&
                    !(w_d_clr && (d_source == SOURCE_W'(i)));
    end
  end
  assign w_timeout = |w_to_hit;

  // Timers restart on each request and saturate at TIMEOUT so code 9 fires once
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) r_tmr[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_a_set && (a_source == SOURCE_W'(i))) r_tmr[i] <= '0;
        else if (r_vld[i] && (r_tmr[i] != TMR_W'(TIMEOUT))) r_tmr[i] <= r_tmr[i] + TMR_W'(1);
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Gather every violation seen this cycle
  always_comb begin
    w_vec = '0;
    if (w_a_fire) begin
      if (!(a_opcode inside {PUT_FULL, PUT_PARTIAL, GET}) || (a_param != 3'd0)) w_vec[0] = 1'b1;
      if (w_misalign) w_vec[1] = 1'b1;
      if ((a_opcode == PUT_FULL) && ((a_mask & w_full_mask) != w_full_mask)) w_vec[2] = 1'b1;
      if (!w_a_first && ((a_opcode != r_ab_opcode) || (a_param != r_ab_param) ||
                         (a_size != r_ab_size) || (a_source != r_ab_source))) w_vec[3] = 1'b1;
      if (w_a_first && w_a_busy) w_vec[5] = 1'b1;
    end
    if (r_a_pend && (!a_valid || (a_opcode != r_ah_opcode) || (a_param != r_ah_param) ||
                     (a_size != r_ah_size) || (a_source != r_ah_source) ||
                     (a_address != r_ah_address) || (a_mask != r_ah_mask))) w_vec[3] = 1'b1;
    if (r_d_pend && (!d_valid || (d_opcode != r_dh_opcode) || (d_size != r_dh_size) ||
                     (d_source != r_dh_source) || (d_denied != r_dh_denied) ||
                     (d_corrupt != r_dh_corrupt))) w_vec[4] = 1'b1;
    if (w_d_fire && w_d_first) begin
      if (!r_vld[d_source]) w_vec[6] = 1'b1;
      else if ((d_opcode != (r_is_get[d_source] ? ACK_DATA : ACK)) ||
               (d_size != r_size[d_source])) w_vec[7] = 1'b1;
    end
    w_vec[8] = w_timeout;
  end

  // Burst headers, stall history and the request table
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ab_opcode  <= '0;
      r_ab_param   <= '0;
      r_ab_size    <= '0;
      r_ab_source  <= '0;
      r_d_match    <= 1'b0;
      r_a_pend     <= 1'b0;
      r_d_pend     <= 1'b0;
      r_ah_opcode  <= '0;
      r_ah_param   <= '0;
      r_ah_size    <= '0;
      r_ah_source  <= '0;
      r_ah_address <= '0;
      r_ah_mask    <= '0;
      r_dh_opcode  <= '0;
      r_dh_size    <= '0;
      r_dh_source  <= '0;
      r_dh_denied  <= 1'b0;
      r_dh_corrupt <= 1'b0;
      r_vld        <= '0;
      r_is_get     <= '0;
      for (int i = 0; i < NSRC; i++) r_size[i] <= '0;
    end else begin
      if (w_a_set) begin
        r_ab_opcode <= a_opcode;
        r_ab_param  <= a_param;
        r_ab_size   <= a_size;
        r_ab_source <= a_source;
      end
      if (w_d_fire && w_d_first) r_d_match <= r_vld[d_source];
      r_a_pend     <= a_valid & ~a_ready;
      r_d_pend     <= d_valid & ~d_ready;
      r_ah_opcode  <= a_opcode;
      r_ah_param   <= a_param;
      r_ah_size    <= a_size;
      r_ah_source  <= a_source;
      r_ah_address <= a_address;
      r_ah_mask    <= a_mask;
      r_dh_opcode  <= d_opcode;
      r_dh_size    <= d_size;
      r_dh_source  <= d_source;
      r_dh_denied  <= d_denied;
      r_dh_corrupt <= d_corrupt;
      r_vld        <= w_vld_n;
      r_is_get     <= w_is_get_n;
      r_size       <= w_size_n;
    end
  end

  // Registered error report, saturating violation-cycle count and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_vec   <= '0;
      r_err_code  <= '0;
      r_err_count <= '0;
      r_inflight  <= '0;
    end else begin
      r_err_valid <= |w_vec;
      r_err_vec   <= w_vec;
      r_err_code  <= lowest_code(w_vec);
      if ((|w_vec) && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      r_inflight  <= w_infl_n;
    end
  end

  assign err_valid = r_err_valid;
  assign err_vec   = r_err_vec;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_tl_ul_monitor.sv
// Self-checking bench for tl_ul_monitor: directed A/D traffic with a per-cycle expectation scoreboard.
// Latency: each driven cycle's expectation is compared one cycle later on the falling edge.
// Backpressure: the bench drives a_ready/d_ready itself to create stalls.
module tb_tl_ul_monitor;

  localparam int SOURCE_W = 2;
  localparam int ADDR_W   = 30;
  localparam int DATA_W   = 32;
  localparam int SIZE_W   = 3;
  localparam int TIMEOUT  = 16;

`ifdef TL_MON_TIMEOUT_EN
  localparam logic [8:0] TO_BIT = 9'h100;
`else
  localparam logic [8:0] TO_BIT = 9'h000;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                a_valid, a_ready;
  logic [2:0]          a_opcode, a_param;
  logic [SIZE_W-1:0]   a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [DATA_W/8-1:0] a_mask;
  logic                d_valid, d_ready;
  logic [2:0]          d_opcode;
  logic [SIZE_W-1:0]   d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied, d_corrupt;
  logic                err_valid;
  logic [8:0]          err_vec;
  logic [3:0]          err_code;
  logic [15:0]         err_count;
  logic [SOURCE_W:0]   inflight;

  always #5 clock = ~clock;

  tl_ul_monitor #(
    .SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .err_valid(err_valid), .err_vec(err_vec), .err_code(err_code),
    .err_count(err_count), .inflight(inflight)
  );

  typedef struct {
    int         due;
    logic [8:0] vec;
    logic [2:0] infl;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;
  string       phase = "reset";

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] first_code(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  // Scoreboard: pop expectations whose result is due this cycle
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      if (e.vec != 9'd0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk("err_valid", 32'(err_valid), 32'(|e.vec));
      chk("err_vec",   32'(err_vec),   32'(e.vec));
      chk("err_code",  32'(err_code),  32'(first_code(e.vec)));
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      chk("inflight",  32'(inflight),  32'(e.infl));
    end
  end

  task automatic idle();
    a_valid = 0; a_ready = 0; a_opcode = 0; a_param = 0; a_size = 0;
    a_source = 0; a_address = 0; a_mask = 0;
    d_valid = 0; d_ready = 0; d_opcode = 0; d_size = 0; d_source = 0;
    d_denied = 0; d_corrupt = 0;
  endtask

  task automatic a_drv(input logic v, input logic r, input logic [2:0] op, input logic [2:0] sz,
                       input logic [1:0] src, input logic [29:0] addr, input logic [3:0] mask);
    a_valid = v; a_ready = r; a_opcode = op; a_param = 3'd0; a_size = sz;
    a_source = src; a_address = addr; a_mask = mask;
  endtask

  task automatic d_drv(input logic v, input logic r, input logic [2:0] op, input logic [2:0] sz,
                       input logic [1:0] src);
    d_valid = v; d_ready = r; d_opcode = op; d_size = sz; d_source = src;
  endtask

  // Commit the current inputs for one cycle and record what the monitor must report for it
  task automatic step(input logic [8:0] v, input logic [2:0] infl);
    sb_q.push_back('{due: cyc + 1, vec: v, infl: infl});
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clock);
    #1;
    exp_cnt = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_vec",   32'(err_vec),   32'd0);
    chk("rst_err_code",  32'(err_code),  32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_inflight",  32'(inflight),  32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();

    phase = "get_ok";
    a_drv(1, 1, 3'd4, 3'd2, 2'd1, 30'h40, 4'hF); step(9'h000, 1);
    step(9'h000, 1);
    d_drv(1, 1, 3'd1, 3'd2, 2'd1);               step(9'h000, 0);

    phase = "misalign";
    a_drv(1, 1, 3'd4, 3'd2, 2'd0, 30'h42, 4'hF); step(9'h002, 1);
    d_drv(1, 1, 3'd1, 3'd2, 2'd0);               step(9'h000, 0);

    phase = "a_stall";
    a_drv(1, 0, 3'd4, 3'd2, 2'd2, 30'h40, 4'hF); step(9'h000, 0);
    a_drv(1, 0, 3'd4, 3'd2, 2'd2, 30'h44, 4'hF); step(9'h008, 0);
    a_drv(1, 0, 3'd4, 3'd2, 2'd2, 30'h44, 4'hF); step(9'h000, 0);
    a_drv(1, 1, 3'd4, 3'd2, 2'd2, 30'h44, 4'hF); step(9'h000, 1);
    d_drv(1, 1, 3'd1, 3'd2, 2'd2);               step(9'h000, 0);

    phase = "a_drop";
    a_drv(1, 0, 3'd4, 3'd2, 2'd0, 30'h40, 4'hF); step(9'h000, 0);
    step(9'h008, 0);

    phase = "d_drop";
    d_drv(1, 0, 3'd1, 3'd2, 2'd1);               step(9'h000, 0);
    step(9'h010, 0);

    phase = "orphan";
    d_drv(1, 1, 3'd0, 3'd2, 2'd3);               step(9'h040, 0);

    phase = "mismatch";
    a_drv(1, 1, 3'd4, 3'd2, 2'd3, 30'h40, 4'hF); step(9'h000, 1);
    step(9'h000, 1);
    d_drv(1, 1, 3'd0, 3'd2, 2'd3);               step(9'h080, 0);

    phase = "put_burst";
    for (int b = 0; b < 4; b++) begin
      a_drv(1, 1, 3'd0, 3'd4, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    end
    d_drv(1, 1, 3'd0, 3'd4, 2'd0);               step(9'h000, 0);

    phase = "busy";
    a_drv(1, 1, 3'd0, 3'd2, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    a_drv(1, 1, 3'd0, 3'd2, 2'd0, 30'h40, 4'hF); step(9'h020, 1);
    d_drv(1, 1, 3'd0, 3'd2, 2'd0);               step(9'h000, 0);

    phase = "bad_op";
    a_drv(1, 1, 3'd3, 3'd2, 2'd1, 30'h40, 4'hF); step(9'h001, 1);
    d_drv(1, 1, 3'd0, 3'd2, 2'd1);               step(9'h000, 0);

    phase = "multi";
    a_drv(1, 1, 3'd5, 3'd2, 2'd3, 30'h41, 4'hF); step(9'h003, 1);
    d_drv(1, 1, 3'd0, 3'd2, 2'd3);               step(9'h000, 0);

    phase = "mask";
    a_drv(1, 1, 3'd0, 3'd1, 2'd1, 30'h42, 4'b0100); step(9'h004, 1);
    d_drv(1, 1, 3'd0, 3'd1, 2'd1);                  step(9'h000, 0);
    a_drv(1, 1, 3'd1, 3'd1, 2'd1, 30'h42, 4'b0100); step(9'h000, 1);
    d_drv(1, 1, 3'd0, 3'd1, 2'd1);                  step(9'h000, 0);

    phase = "swap";
    a_drv(1, 1, 3'd4, 3'd2, 2'd1, 30'h40, 4'hF); step(9'h000, 1);
    step(9'h000, 1);
    a_drv(1, 1, 3'd4, 3'd2, 2'd1, 30'h40, 4'hF);
    d_drv(1, 1, 3'd1, 3'd2, 2'd1);               step(9'h000, 1);
    d_drv(1, 1, 3'd1, 3'd2, 2'd1);               step(9'h000, 0);

    phase = "zero_lat";
    a_drv(1, 1, 3'd4, 3'd2, 2'd2, 30'h40, 4'hF);
    d_drv(1, 1, 3'd1, 3'd2, 2'd2);               step(9'h040, 1);
    d_drv(1, 1, 3'd1, 3'd2, 2'd2);               step(9'h000, 0);

    phase = "mid_burst";
    a_drv(1, 1, 3'd0, 3'd3, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    a_drv(1, 1, 3'd0, 3'd3, 2'd1, 30'h40, 4'hF); step(9'h008, 1);
    d_drv(1, 1, 3'd0, 3'd3, 2'd0);               step(9'h000, 0);

    phase = "reset_mid";
    a_drv(1, 1, 3'd0, 3'd4, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    a_drv(1, 1, 3'd0, 3'd4, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    do_reset();
    a_drv(1, 1, 3'd0, 3'd2, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    d_drv(1, 1, 3'd0, 3'd2, 2'd0);               step(9'h000, 0);

    phase = "timeout";
    a_drv(1, 1, 3'd4, 3'd2, 2'd0, 30'h40, 4'hF); step(9'h000, 1);
    for (int k = 1; k < TIMEOUT; k++) step(9'h000, 1);
    step(TO_BIT, 1);
    repeat (3) step(9'h000, 1);
    d_drv(1, 1, 3'd1, 3'd2, 2'd0);               step(9'h000, 0);
    step(9'h000, 0);

    phase = "end";
    @(negedge clock);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
